// File: rtl/fft_frame_scheduler_if.sv
// Sample streams of the frame scheduler: input samples in, FFT results out.
// The host side (master) drives samples and accepts results; the scheduler is the slave.
interface fft_frame_scheduler_if #(parameter int DATA_W = 64);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_last;

  modport master (output in_valid, output in_data, input in_ready,
                  input out_valid, input out_data, input out_last, output out_ready);
  modport slave  (input in_valid, input in_data, output in_ready,
                  output out_valid, output out_data, output out_last, input out_ready);
endinterface

// File: rtl/fft_frame_scheduler.sv
// Frame sequencer for the 32-point FFT: loads a frame into bank 0, kicks the engine,
// waits for completion plus write drain, then streams results out of the result bank.
module fft_frame_scheduler #(
  parameter int N_POINTS    = 32,
  parameter int ADDR_W      = 5,
  parameter int DATA_W      = 64,
  parameter int DRAIN_CYC   = 9,
  parameter bit RESULT_BANK = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  fft_frame_scheduler_if.slave io,
  output logic                 start_fft,
  input  logic                 fft_done,
  output logic                 mem_host,
  output logic                 host_bank,
  output logic                 host_we,
  output logic [ADDR_W-1:0]    host_addr,
  output logic [DATA_W-1:0]    host_wdata,
  input  logic [DATA_W-1:0]    host_rdata,
  output logic                 busy,
  output logic [15:0]          frame_cnt
);
  typedef enum logic [2:0] {IDLE, LOAD, START, RUN, DRAIN, UNLOAD} state_t;

  localparam logic [ADDR_W-1:0]  LAST_IDX   = ADDR_W'(N_POINTS - 1);
  localparam logic [ADDR_W:0]    RD_TOTAL   = (ADDR_W + 1)'(N_POINTS);
  localparam int                 DRAIN_W    = $clog2(DRAIN_CYC + 1);
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_CYC - 1);

  state_t             state_reg, state_next;
  logic [ADDR_W-1:0]  wr_cnt_reg;
  logic [ADDR_W-1:0]  wr_addr_reg;
  logic               we_reg;
  logic [DATA_W-1:0]  wdata_reg;
  logic               seen_low_reg;
  logic [DRAIN_W-1:0] drain_cnt_reg;
  logic [ADDR_W:0]    rd_cnt_reg;
  logic               inflight_reg;
  logic [ADDR_W-1:0]  out_idx_reg;
  logic               fifo_wptr_reg, fifo_rptr_reg;
  logic [1:0]         fifo_cnt_reg;
  logic [15:0]        frame_cnt_reg;

  logic               in_ready_c;
  logic               in_fire, out_fire, rd_issue;
  logic [2:0]         fifo_occ;

  assign io.in_ready  = in_ready_c & rst_n;
  assign in_fire      = io.in_valid & io.in_ready;
  assign io.out_valid = (fifo_cnt_reg != 2'd0);
  assign out_fire     = io.out_valid & io.out_ready;
  assign io.out_last  = io.out_valid & (out_idx_reg == LAST_IDX);

  // Slots already promised = held entries + read in flight, minus the one leaving now.
  assign fifo_occ = {1'b0, fifo_cnt_reg} + {2'b00, inflight_reg} - {2'b00, out_fire};
  assign rd_issue = (state_reg == UNLOAD) && (rd_cnt_reg < RD_TOTAL) && (fifo_occ < 3'd2);

  assign host_we    = we_reg;
  assign host_wdata = wdata_reg;
  assign host_addr  = (state_reg == UNLOAD) ? rd_cnt_reg[ADDR_W-1:0] : wr_addr_reg;
  assign frame_cnt  = frame_cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:   if (in_fire) state_next = LOAD;
      LOAD:   if (in_fire && wr_cnt_reg == LAST_IDX) state_next = START;
      START:  if (!we_reg) state_next = RUN;
      RUN:    if (fft_done && seen_low_reg) state_next = DRAIN;
      DRAIN:  if (drain_cnt_reg == DRAIN_LAST) state_next = UNLOAD;
      UNLOAD: if (out_fire && out_idx_reg == LAST_IDX) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // START hands the memory to the engine only once the final load write has landed.
  always_comb begin
    in_ready_c = 1'b0;
    start_fft  = 1'b0;
    mem_host   = 1'b1;
    host_bank  = 1'b0;
    busy       = 1'b1;
    case (state_reg)
      IDLE: begin
        in_ready_c = 1'b1;
        busy       = 1'b0;
      end
      LOAD:   in_ready_c = 1'b1;
      START: begin
        mem_host  = we_reg;
        start_fft = ~we_reg;
      end
      RUN, DRAIN: mem_host = 1'b0;
      UNLOAD: host_bank = RESULT_BANK;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_cnt_reg    <= '0;
      wr_addr_reg   <= '0;
      we_reg        <= 1'b0;
      wdata_reg     <= '0;
      seen_low_reg  <= 1'b0;
      drain_cnt_reg <= '0;
      rd_cnt_reg    <= '0;
      inflight_reg  <= 1'b0;
      out_idx_reg   <= '0;
      frame_cnt_reg <= '0;
    end else begin
      we_reg <= in_fire;
      if (in_fire) begin
        wr_addr_reg <= wr_cnt_reg;
        wdata_reg   <= io.in_data;
        wr_cnt_reg  <= wr_cnt_reg + 1'b1;
      end
      // fft_done only counts as an edge once it has been observed low inside RUN.
      if (state_reg == START)               seen_low_reg <= 1'b0;
      else if (state_reg == RUN && !fft_done) seen_low_reg <= 1'b1;
      drain_cnt_reg <= (state_reg == DRAIN) ? drain_cnt_reg + 1'b1 : '0;
      if (state_reg != UNLOAD) rd_cnt_reg <= '0;
      else if (rd_issue)       rd_cnt_reg <= rd_cnt_reg + 1'b1;
      inflight_reg <= rd_issue;
      if (out_fire) begin
        out_idx_reg <= out_idx_reg + 1'b1;
        if (out_idx_reg == LAST_IDX) frame_cnt_reg <= frame_cnt_reg + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_wptr_reg <= 1'b0;
      fifo_rptr_reg <= 1'b0;
      fifo_cnt_reg  <= 2'd0;
    end else begin
      if (inflight_reg) fifo_wptr_reg <= ~fifo_wptr_reg;
      if (out_fire)     fifo_rptr_reg <= ~fifo_rptr_reg;
      case ({inflight_reg, out_fire})
        2'b10:   fifo_cnt_reg <= fifo_cnt_reg + 2'd1;
        2'b01:   fifo_cnt_reg <= fifo_cnt_reg - 2'd1;
        default: fifo_cnt_reg <= fifo_cnt_reg;
      endcase
    end
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_skid
    logic [DATA_W-1:0] entry_reg;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
        entry_reg <= '0;
      else if (inflight_reg && fifo_wptr_reg == 1'(gi))
        entry_reg <= host_rdata;
    end
  end

  assign io.out_data = fifo_rptr_reg ? g_skid[1].entry_reg : g_skid[0].entry_reg;
endmodule
